patching_controller: RTL and testbench
======================================

Name: patching_controller

Overview:
- Sequencing controller for the activation-patching datapath.
- Keeps a small per-index cache of previously seen activations and compares each incoming activation with its cached entry.
- Produces the original activation, the cached activation and the patch bit p that drive the patching mux.
- p=1 means the cached value is reused and downstream recomputation is skipped; p=0 means the original is used and the cache is refreshed.
- Sits between the activation producer and the patching mux / downstream MAC stage; valid/ready on both sides.

Parameters:
- N, 16, activation width in bits (unsigned).
- DEPTH, 8, number of cache entries; power of two, at least 2.
- IDX_W, $clog2(DEPTH), index width (derived).
- CNT_W, 16, width of the hit counter.

Ports:
- clk  input  1  clock; everything is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input activation valid.
- in_ready  output  1  controller can accept an input.
- in_act  input  N  original activation.
- in_idx  input  IDX_W  neuron/cache index for in_act.
- threshold  input  N  maximum unsigned difference that still counts as a hit; quasi-static.
- flush  input  1  single-cycle request to invalidate the whole cache.
- out_valid  output  1  output bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- a_org  output  N  registered copy of in_act.
- a_cache  output  N  cached activation to the patching mux.
- p  output  1  patch bit to the patching mux.
- hit_count  output  CNT_W  saturating count of hits since reset or the last flush.
- busy  output  1  high while in FLUSH.

Behaviour:
- Reset (async, rst=1):
  - state=RUN; all valid bits=0; cache data=0.
  - out_valid=0, a_org=0, a_cache=0, p=0.
  - hit_count=0, busy=0, flush pointer=0.
  - Reset asserted mid-flush or mid-transfer discards everything immediately.
- FSM has two states, RUN and FLUSH:
  - RUN -> FLUSH when flush=1 is sampled in RUN.
  - FLUSH -> RUN after the entry at index DEPTH-1 is cleared.
  - flush asserted while in FLUSH is ignored.
- Flush timing and counter:
  - FLUSH clears one valid bit per cycle, indices 0..DEPTH-1, so it takes exactly DEPTH cycles.
  - busy=1 throughout FLUSH.
  - hit_count clears on the cycle the FSM enters FLUSH.
- in_ready = (state==RUN) && !flush && (!out_valid || out_ready).
  - flush takes priority over input: no transfer happens in the same cycle a flush is sampled.
- A transfer occurs when in_valid && in_ready. On that clock edge:
  - diff = |in_act - cache[in_idx]|, computed at N+1 bits with no wrap.
  - hit = valid[in_idx] && (diff <= threshold).
  - Output register loads: a_org=in_act; a_cache=cache[in_idx] (pre-update value, 0 if invalid); p=hit; out_valid=1.
  - On a miss, cache[in_idx] is written with in_act and valid[in_idx]=1.
  - On a hit, the cache is unchanged and hit_count increments, saturating at 2^CNT_W-1.
- Latency is 1 cycle from the accepting edge to out_valid. Throughput is 1 per cycle when out_ready=1.
- Back-to-back inputs to the same index see the update from the previous cycle; there is no stale read.
- The output holds stable while out_valid && !out_ready.
  - out_valid clears after out_ready when no new transfer occurs that cycle.
- The output register keeps draining during FLUSH; only inputs are blocked.
- threshold=0 means only an exact match is a hit.
- threshold = 2^N-1 means any valid entry is a hit.

Test Plan:
- Cold miss: N=16, threshold=4, after reset send idx=3 act=100 -> next cycle out_valid=1, p=0, a_org=100, a_cache=0; hit_count=0.
- Hit inside threshold: then send idx=3 act=103 -> p=1, a_cache=100, a_org=103, hit_count=1; entry 3 still holds 100. Then send idx=3 act=105 -> p=0 (diff=5); entry 3 becomes 105.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after the first transfer, outputs stable; release -> one bundle per cycle, no loss or duplication.
- Flush: after filling idx 0..7, pulse flush with in_valid=1 in the same cycle -> no transfer that cycle; busy=1 for exactly 8 cycles; hit_count=0. Afterwards idx=0 act=0 -> p=0.
- Wrap and saturation: threshold=0, act=0xFFFF vs cached 0x0000 -> diff=0xFFFF, p=0. Force 2^CNT_W hits -> hit_count stays at 0xFFFF.
- Async reset mid-flush, at cycle 4 of FLUSH -> immediately busy=0, out_valid=0, all entries invalid; the first post-reset input gives p=0.

Source files
------------

// File: rtl/patching_controller.sv
// -----------------------------------------------------------------------------
// patching_controller
//
// Sequencing controller for the activation-patching datapath. A small cache,
// indexed by neuron index, holds the last refreshed activation of each
// neuron. Every accepted activation is compared against its cached entry:
//   - close enough (|in_act - cache| <= threshold, entry valid) -> hit:
//     p=1, the cached value is reused and the cache is left untouched;
//   - otherwise -> miss: p=0, the original is used and the cache entry is
//     refreshed with it.
// The result bundle (a_org, a_cache, p) is registered and presented to the
// patching mux one cycle after acceptance, with valid/ready on both sides.
// A flush request walks the cache invalidating one entry per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input activation valid
//   in_ready   controller can accept an input this cycle
//   in_act     original activation (unsigned, N bits)
//   in_idx     neuron / cache index of in_act
//   threshold  largest difference still counted as a hit (quasi-static)
//   flush      single-cycle request to invalidate the whole cache
//   out_valid  output bundle valid
//   out_ready  downstream accepts the bundle
//   a_org      registered copy of the accepted activation
//   a_cache    cached activation (pre-update value, 0 if entry invalid)
//   p          patch bit: 1 = reuse cached value, 0 = use original
//   hit_count  saturating hit count since reset or the last flush
//   busy       high while the cache is being flushed
// -----------------------------------------------------------------------------
module patching_controller #(
    parameter int N     = 16,
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_act,
    input  logic [IDX_W-1:0] in_idx,
    input  logic [N-1:0]     threshold,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     a_org,
    output logic [N-1:0]     a_cache,
    output logic             p,
    output logic [CNT_W-1:0] hit_count,
    output logic             busy
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // Cache storage: data plus one valid bit per entry.
    logic [N-1:0]     cache [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [IDX_W-1:0] flush_ptr;

    // Lookup and comparison for the entry addressed by the current input.
    logic             cached_valid;
    logic [N-1:0]     cached_data;
    logic [N:0]       diff;
    logic             hit;
    logic             xfer;
    logic             flush_start;
    logic             flush_last;

    assign cached_valid = valid[in_idx];
    assign cached_data  = cache[in_idx];

    // Absolute difference at N+1 bits so that no operand order can wrap.
    always_comb begin
        if (in_act >= cached_data) begin
            diff = {1'b0, in_act} - {1'b0, cached_data};
        end else begin
            diff = {1'b0, cached_data} - {1'b0, in_act};
        end
    end

    assign hit         = cached_valid && (diff <= {1'b0, threshold});
    assign xfer        = in_valid && in_ready;
    assign flush_start = (state == RUN) && flush;
    assign flush_last  = (state == FLUSH) && (flush_ptr == IDX_W'(DEPTH - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever branch is taken.
    always_comb begin
        state_next = state;
        unique case (state)
            RUN:   if (flush)      state_next = FLUSH;
            FLUSH: if (flush_last) state_next = RUN;
            default:               state_next = RUN;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // A flush sampled this cycle blocks the input, so no transfer can race
    // with the start of the invalidation walk.
    always_comb begin
        busy     = (state == FLUSH);
        in_ready = (state == RUN) && !flush && (!out_valid || out_ready);
    end

    // -------------------------------------------------------------------------
    // Flush pointer: walks 0..DEPTH-1, one entry per FLUSH cycle. DEPTH is a
    // power of two, so the increment after the last entry returns it to 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_ptr <= '0;
        end else if (flush_start) begin
            flush_ptr <= '0;
        end else if (state == FLUSH) begin
            flush_ptr <= flush_ptr + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Cache data: refreshed on a miss only.
    // -------------------------------------------------------------------------
    // NOTE: the cache is small enough to live in flops, so it is cleared on
    // reset like any other register; a RAM-backed cache could not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cache[i] <= '0;
            end
        end else if (xfer && !hit) begin
            cache[in_idx] <= in_act;
        end
    end

    // Valid bits: cleared one by one during FLUSH, set on a miss. A transfer
    // requires RUN, so the two updates never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (state == FLUSH) begin
            valid[flush_ptr] <= 1'b0;
        end else if (xfer && !hit) begin
            valid[in_idx] <= 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output register. It keeps draining during FLUSH; only inputs stop.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            a_org     <= '0;
            a_cache   <= '0;
            p         <= 1'b0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            a_org     <= in_act;
            a_cache   <= cached_valid ? cached_data : '0;
            p         <= hit;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Hit counter: cleared on flush entry, saturates at all-ones.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= '0;
        end else if (flush_start) begin
            hit_count <= '0;
        end else if (xfer && hit && (hit_count != '1)) begin
            hit_count <= hit_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_patching_controller.sv
// -----------------------------------------------------------------------------
// tb_patching_controller
//
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the cache (plain arrays and integer arithmetic) kept
// in the bench. Inputs are driven on the falling edge; outputs are sampled
// 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_patching_controller;

    localparam int N     = 16;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = 65535;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_act;
    logic [IDX_W-1:0] in_idx;
    logic [N-1:0]     threshold;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     a_org;
    logic [N-1:0]     a_cache;
    logic             p;
    logic [CNT_W-1:0] hit_count;
    logic             busy;

    always #5 clk = ~clk;

    patching_controller #(
        .N     (N),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_act    (in_act),
        .in_idx    (in_idx),
        .threshold (threshold),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_org     (a_org),
        .a_cache   (a_cache),
        .p         (p),
        .hit_count (hit_count),
        .busy      (busy)
    );

    // Counters
    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model
    int m_cache [DEPTH];
    bit m_valid [DEPTH];
    int m_hits;
    int m_flush_left;   // FLUSH cycles still to go; 0 means running
    bit m_ov;
    int m_org;
    int m_acache;
    bit m_p;
    int thr;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_cache[i] = 0;
            m_valid[i] = 1'b0;
        end
        m_hits       = 0;
        m_flush_left = 0;
        m_ov         = 1'b0;
        m_org        = 0;
        m_acache     = 0;
        m_p          = 1'b0;
    endtask

    // One clock cycle: drive inputs, check in_ready/busy, advance the model
    // across the edge, then check the registered outputs.
    task automatic step(input bit v, input int act, input int idx,
                        input bit fl, input bit ordy);
        bit exp_ready;
        int d;
        bit h;
        @(negedge clk);
        in_valid  = v;
        in_act    = act[N-1:0];
        in_idx    = idx[IDX_W-1:0];
        flush     = fl;
        out_ready = ordy;
        threshold = thr[N-1:0];
        #1;
        exp_ready = (m_flush_left == 0) && !fl && (!m_ov || ordy);
        check("in_ready", in_ready, exp_ready);
        check("busy_pre", busy, m_flush_left != 0);

        if (m_flush_left != 0) begin
            m_valid[DEPTH - m_flush_left] = 1'b0;
            m_flush_left--;
        end else if (fl) begin
            m_flush_left = DEPTH;
            m_hits       = 0;
        end

        if (v && exp_ready) begin
            d = act - m_cache[idx];
            if (d < 0) d = -d;
            h        = m_valid[idx] && (d <= thr);
            m_ov     = 1'b1;
            m_org    = act;
            m_acache = m_valid[idx] ? m_cache[idx] : 0;
            m_p      = h;
            if (h) begin
                if (m_hits < CNT_MAX) m_hits++;
            end else begin
                m_cache[idx] = act;
                m_valid[idx] = 1'b1;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end

        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_ov);
        if (m_ov) begin
            check("a_org", a_org, m_org);
            check("a_cache", a_cache, m_acache);
            check("p", p, m_p);
        end
        check("hit_count", hit_count, m_hits);
    endtask

    initial begin
        int busy_cycles;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_act    = '0;
        in_idx    = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        thr       = 4;
        threshold = 16'd4;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_a_org", a_org, 0);
        check("rst_a_cache", a_cache, 0);
        check("rst_p", p, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        // Cold miss, hit inside threshold, miss just outside, refreshed entry.
        step(1, 100, 3, 0, 1);
        check("cold_p", p, 0);
        check("cold_a_org", a_org, 100);
        check("cold_a_cache", a_cache, 0);
        check("cold_hits", hit_count, 0);
        step(1, 103, 3, 0, 1);
        check("hit_p", p, 1);
        check("hit_a_cache", a_cache, 100);
        check("hit_hits", hit_count, 1);
        step(1, 105, 3, 0, 1);
        check("miss5_p", p, 0);
        check("miss5_a_cache", a_cache, 100);
        step(1, 105, 3, 0, 1);
        check("refresh_a_cache", a_cache, 105);
        check("refresh_p", p, 1);

        // Backpressure: one transfer, three stalled cycles, then drain.
        step(1, 10, 1, 0, 1);
        for (int k = 0; k < 3; k++) step(1, 20 + k, 1, 0, 0);
        check("stall_a_org", a_org, 10);
        check("stall_in_ready", in_ready, 0);
        for (int k = 0; k < 3; k++) step(1, 30 + k * 20, 1, 0, 1);
        step(0, 0, 0, 0, 1);

        // Fill every entry, then flush with a simultaneous input.
        for (int i = 0; i < DEPTH; i++) step(1, 1000 + i * 50, i, 0, 1);
        step(1, 1000, 0, 1, 1);
        busy_cycles = busy ? 1 : 0;
        check("flush_hits", hit_count, 0);
        for (int k = 0; k < 10; k++) begin
            step(1, 1000 + k, k % DEPTH, 0, 1);
            if (busy) busy_cycles++;
        end
        check("busy_len", busy_cycles, DEPTH);
        step(1, 0, 0, 0, 1);
        check("post_flush_p", p, 0);

        // Randomized traffic around a few base values so hits and misses mix.
        for (int k = 0; k < 300; k++) begin
            int idx;
            int act;
            idx = $urandom_range(DEPTH - 1);
            act = 500 + idx * 40 + $urandom_range(12);
            if ($urandom_range(15) == 0) thr = $urandom_range(8);
            step($urandom_range(3) != 0, act, idx, $urandom_range(40) == 0,
                 $urandom_range(3) != 0);
        end
        for (int k = 0; k < DEPTH + 2; k++) step(0, 0, 0, 0, 1);

        // Exact-match threshold and full-scale difference.
        thr = 0;
        step(1, 0, 5, 0, 1);
        step(1, 16'hFFFF, 5, 0, 1);
        check("wrap_p", p, 0);
        check("wrap_a_cache", a_cache, 0);
        check("wrap_a_org", a_org, 16'hFFFF);

        // Hit counter saturation: prime an entry, then stream identical hits.
        step(1, 16'h1234, 2, 0, 1);
        step(1, 16'h1234, 2, 0, 1);
        check("sat_prime_p", p, 1);
        repeat (CNT_MAX + 5) @(posedge clk);
        #1;
        m_hits   = CNT_MAX;
        m_ov     = 1'b1;
        m_org    = 16'h1234;
        m_acache = 16'h1234;
        m_p      = 1'b1;
        check("sat_hits", hit_count, CNT_MAX);
        step(1, 16'h1234, 2, 0, 1);
        check("sat_hold", hit_count, CNT_MAX);

        // Asynchronous reset during the fourth FLUSH cycle.
        thr = 4;
        step(1, 700, 6, 0, 1);
        step(1, 0, 0, 1, 1);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_a_org", a_org, 0);
        check("arst_hits", hit_count, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(1, 700, 6, 0, 1);
        check("arst_first_p", p, 0);
        check("arst_first_a_cache", a_cache, 0);
        step(1, 701, 6, 0, 1);
        check("arst_second_p", p, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
